uart_tx_buffered: RTL and testbench

Buffered RS-232 transmitter: accepts bytes from on-chip logic through a FIFO and serialises them on TxD as 8 data bits, LSB first, no parity, 2 stop bits. It is the transmit-side counterpart to the board's UART receive path. It sits between the flight-controller telemetry logic and the TxD pin. Baud timing comes from an internal fractional accumulator, so no external tick is needed.

---
 rtl/uart_tx_buffered.sv | 126 ++++++++++++
 tb/tb_uart_tx_buffered.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffered.sv
// Buffered RS-232 transmitter: byte FIFO feeding an 8N2 serialiser.
// Bit timing comes from an internal fractional baud accumulator.
module uart_tx_buffered #(
    parameter int ClkFrequency = 50000000,
    parameter int Baud         = 115200,
    parameter int FifoDepth    = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         TxD_start,
    input  logic [7:0]                   TxD_data,
    output logic                         TxD_ready,
    output logic                         TxD,
    output logic                         TxD_busy,
    output logic [$clog2(FifoDepth):0]   fifo_count
);
    localparam int PtrW     = $clog2(FifoDepth);
    localparam int AccWidth = $clog2(ClkFrequency / Baud + 1) + 8;
    localparam logic [63:0] IncFull =
        ((64'(Baud) << AccWidth) + 64'(ClkFrequency / 2)) / 64'(ClkFrequency);
    localparam logic [AccWidth:0] Inc = IncFull[AccWidth:0];

    if (ClkFrequency < 2 * Baud) begin : gBadBaud
        $error("uart_tx_buffered: ClkFrequency must be at least 2*Baud");
    end
    if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : gBadDepth
        $error("uart_tx_buffered: FifoDepth must be a power of 2 and at least 2");
    end

    typedef enum logic [3:0] {
        IDLE, START, D0, D1, D2, D3, D4, D5, D6, D7, STOP1, STOP2
    } state_t;

    logic [7:0]      mem [FifoDepth];
    logic [PtrW-1:0] wrPtr, rdPtr;
    logic [PtrW:0]   count;
    logic            push, pop;

    state_t            state, stateNext;
    logic [7:0]        shifter;
    logic [AccWidth:0] acc, accSum;
    logic              tick, txdNext;
    logic [2:0]        bitSel;

    assign TxD_ready  = (count != (PtrW + 1)'(FifoDepth));
    assign push       = TxD_start && TxD_ready;
    assign fifo_count = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage is data only; emptiness is tracked by the pointers and counter.
    always_ff @(posedge clk) begin
        if (push) mem[wrPtr] <= TxD_data;
        if (pop)  shifter <= mem[rdPtr];
    end

    // The carry out of this cycle's addition is the tick, so a bit ends on the
    // same edge the accumulator overflows and every bit is a whole period long.
    assign accSum = {1'b0, acc[AccWidth-1:0]} + Inc;
    assign tick   = accSum[AccWidth];

    always_comb begin
        stateNext = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    stateNext = START;
                end
            end
            STOP2: begin
                if (tick) begin
                    if (count != '0) begin
                        pop       = 1'b1;
                        stateNext = START;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            default: begin
                if (tick) stateNext = state_t'(state + 4'd1);
            end
        endcase
    end

    always_comb begin
        bitSel  = 3'(4'(stateNext) - 4'(D0));
        txdNext = 1'b1;
        if (stateNext == START) begin
            txdNext = 1'b0;
        end else if (stateNext >= D0 && stateNext <= D7) begin
            txdNext = shifter[bitSel];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            acc      <= '0;
            TxD      <= 1'b1;
            TxD_busy <= 1'b0;
        end else begin
            state    <= stateNext;
            acc      <= (state == IDLE || pop) ? '0 : accSum;
            TxD      <= txdNext;
            TxD_busy <= (stateNext != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered against a frame-schedule model.
module tb_uart_tx_buffered;
    localparam int ClkFrequency = 1600000;
    localparam int Baud         = 100000;
    localparam int FifoDepth    = 4;
    localparam int BitClks      = 16;
    localparam int FrameClks    = 176;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       TxD_start = 1'b0;
    logic [7:0] TxD_data = 8'h00;
    logic       TxD_ready, TxD, TxD_busy;
    logic [2:0] fifo_count;

    int nCmp = 0;
    int nFail = 0;
    int cyc = 0;

    // Model: each accepted byte gets an accept time and a frame start time.
    int         accT[$];
    logic [7:0] accD[$];
    int         frS[$];

    always #5 clk = ~clk;

    uart_tx_buffered #(
        .ClkFrequency(ClkFrequency),
        .Baud(Baud),
        .FifoDepth(FifoDepth)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .TxD_start(TxD_start),
        .TxD_data(TxD_data),
        .TxD_ready(TxD_ready),
        .TxD(TxD),
        .TxD_busy(TxD_busy),
        .fifo_count(fifo_count)
    );

    function automatic int modelCount(int t);
        int c = 0;
        foreach (accT[i]) if (accT[i] <= t) c++;
        foreach (frS[i]) if (frS[i] <= t) c--;
        return c;
    endfunction

    // {TxD, TxD_busy, TxD_ready, fifo_count} expected just after edge t.
    function automatic logic [5:0] modelOut(int t);
        int c, k;
        logic txd, busy;
        logic [7:0] d;
        c = modelCount(t);
        txd = 1'b1;
        busy = 1'b0;
        foreach (frS[i]) begin
            if (t >= frS[i] && t < frS[i] + FrameClks) begin
                busy = 1'b1;
                k = (t - frS[i]) / BitClks;
                d = accD[i];
                if (k == 0) txd = 1'b0;
                else if (k <= 8) txd = d[k-1];
                else txd = 1'b1;
            end
        end
        return {txd, busy, (c < FifoDepth), 3'(c)};
    endfunction

    function automatic int modelEnd();
        if (frS.size() == 0) return 0;
        return frS[frS.size()-1] + FrameClks;
    endfunction

    task automatic resetModel();
        accT.delete();
        accD.delete();
        frS.delete();
    endtask

    task automatic advance();
        logic acc;
        int s;
        acc = rst_n && TxD_start && (modelCount(cyc) < FifoDepth);
        @(posedge clk);
        cyc++;
        if (acc) begin
            s = cyc + 1;
            if (frS.size() > 0 && frS[frS.size()-1] + FrameClks > s)
                s = frS[frS.size()-1] + FrameClks;
            accT.push_back(cyc);
            accD.push_back(TxD_data);
            frS.push_back(s);
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            advance();
            nCmp++;
            if ({TxD, TxD_busy, TxD_ready, fifo_count} !== 6'b101000) begin
                nFail++;
                $display("FAIL reset_state cyc=%0d got=%b exp=%b", cyc,
                         {TxD, TxD_busy, TxD_ready, fifo_count}, 6'b101000);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            advance();
            nCmp++;
            if ({TxD, TxD_busy, TxD_ready, fifo_count} !== modelOut(cyc)) begin
                nFail++;
                $display("FAIL idle_after_reset cyc=%0d got=%b exp=%b", cyc,
                         {TxD, TxD_busy, TxD_ready, fifo_count}, modelOut(cyc));
            end
        end
    endtask

    task automatic test_single();
        int n, fallT, busyFallT;
        logic prevTxd, prevBusy;
        logic [10:0] seq;
        fallT = -1;
        busyFallT = -1;
        seq = '0;
        TxD_data = 8'hA5;
        TxD_start = 1'b1;
        advance();
        n = cyc;
        TxD_start = 1'b0;
        TxD_data = 8'($urandom);
        nCmp++;
        if (fifo_count !== 3'd1) begin
            nFail++;
            $display("FAIL single_latency_count got=%0d exp=1", fifo_count);
        end
        for (int i = 0; i < 200; i++) begin
            prevTxd = TxD;
            prevBusy = TxD_busy;
            advance();
            nCmp++;
            if ({TxD, TxD_busy, TxD_ready, fifo_count} !== modelOut(cyc)) begin
                nFail++;
                $display("FAIL single_line cyc=%0d got=%b exp=%b", cyc,
                         {TxD, TxD_busy, TxD_ready, fifo_count}, modelOut(cyc));
            end
            if (fallT < 0 && prevTxd && !TxD) fallT = cyc;
            if (busyFallT < 0 && prevBusy && !TxD_busy) busyFallT = cyc;
            if (cyc >= n + 1 && cyc < n + 177 && (cyc - n - 1) % BitClks == 8)
                seq[(cyc - n - 1) / BitClks] = TxD;
        end
        nCmp++;
        if (fallT !== n + 1) begin
            nFail++;
            $display("FAIL single_txd_fall got=N+%0d exp=N+1", fallT - n);
        end
        nCmp++;
        if (busyFallT !== n + 177) begin
            nFail++;
            $display("FAIL single_busy_fall got=N+%0d exp=N+177", busyFallT - n);
        end
        nCmp++;
        if (seq !== 11'b11101001010) begin
            nFail++;
            $display("FAIL single_bits got=%b exp=%b", seq, 11'b11101001010);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d [3] = '{8'h00, 8'hFF, 8'h55};
        logic [2:0] expCnt [3] = '{3'd1, 3'd1, 3'd2};
        int falls [3];
        int nFalls, n;
        logic prevTxd;
        nFalls = 0;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            TxD_data = d[i];
            TxD_start = 1'b1;
            prevTxd = TxD;
            advance();
            if (i == 0) n = cyc;
            if (prevTxd && !TxD && nFalls < 3) begin falls[nFalls] = cyc; nFalls++; end
            nCmp++;
            if (fifo_count !== expCnt[i]) begin
                nFail++;
                $display("FAIL b2b_count%0d got=%0d exp=%0d", i, fifo_count, expCnt[i]);
            end
        end
        TxD_start = 1'b0;
        while (cyc < n + 1 + 3 * FrameClks + 5) begin
            prevTxd = TxD;
            advance();
            if (prevTxd && !TxD && nFalls < 3) begin falls[nFalls] = cyc; nFalls++; end
            nCmp++;
            if ({TxD, TxD_busy, TxD_ready, fifo_count} !== modelOut(cyc)) begin
                nFail++;
                $display("FAIL b2b_line cyc=%0d got=%b exp=%b", cyc,
                         {TxD, TxD_busy, TxD_ready, fifo_count}, modelOut(cyc));
            end
        end
        nCmp++;
        if (nFalls != 3) begin
            nFail++;
            $display("FAIL b2b_frame_starts got=%0d exp=3", nFalls);
        end else begin
            nCmp++;
            if (falls[0] != n + 1) begin
                nFail++;
                $display("FAIL b2b_first_start got=N+%0d exp=N+1", falls[0] - n);
            end
            for (int i = 1; i < 3; i++) begin
                nCmp++;
                if (falls[i] - falls[i-1] != FrameClks) begin
                    nFail++;
                    $display("FAIL b2b_spacing%0d got=%0d exp=%0d", i,
                             falls[i] - falls[i-1], FrameClks);
                end
            end
        end
    endtask

    task automatic test_fill();
        int dutAcc, riseT, fallT;
        logic prevBusy;
        dutAcc = 0;
        riseT = -1;
        fallT = -1;
        TxD_start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            TxD_data = 8'($urandom);
            if (TxD_start && TxD_ready) dutAcc++;
            prevBusy = TxD_busy;
            advance();
            if (riseT < 0 && !prevBusy && TxD_busy) riseT = cyc;
            nCmp++;
            if ({TxD, TxD_busy, TxD_ready, fifo_count} !== modelOut(cyc)) begin
                nFail++;
                $display("FAIL fill_line cyc=%0d got=%b exp=%b", cyc,
                         {TxD, TxD_busy, TxD_ready, fifo_count}, modelOut(cyc));
            end
        end
        TxD_start = 1'b0;
        nCmp++;
        if (dutAcc != 5) begin
            nFail++;
            $display("FAIL fill_accepted got=%0d exp=5", dutAcc);
        end
        nCmp++;
        if ({TxD_ready, fifo_count} !== {1'b0, 3'd4}) begin
            nFail++;
            $display("FAIL fill_full got ready=%b count=%0d exp ready=0 count=4",
                     TxD_ready, fifo_count);
        end
        for (int g = 0; g < 1200 && fallT < 0; g++) begin
            prevBusy = TxD_busy;
            advance();
            if (prevBusy && !TxD_busy) fallT = cyc;
            nCmp++;
            if ({TxD, TxD_busy, TxD_ready, fifo_count} !== modelOut(cyc)) begin
                nFail++;
                $display("FAIL fill_line cyc=%0d got=%b exp=%b", cyc,
                         {TxD, TxD_busy, TxD_ready, fifo_count}, modelOut(cyc));
            end
        end
        nCmp++;
        if (riseT < 0 || fallT < 0 || fallT - riseT != 5 * FrameClks) begin
            nFail++;
            $display("FAIL fill_frames busy_len got=%0d exp=%0d", fallT - riseT, 5 * FrameClks);
        end
    endtask

    task automatic test_full_pop_write();
        int n, popT;
        popT = -1;
        n = 0;
        TxD_start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            TxD_data = 8'($urandom);
            advance();
            if (i == 0) n = cyc;
            nCmp++;
            if ({TxD, TxD_busy, TxD_ready, fifo_count} !== modelOut(cyc)) begin
                nFail++;
                $display("FAIL fullpop_line cyc=%0d got=%b exp=%b", cyc,
                         {TxD, TxD_busy, TxD_ready, fifo_count}, modelOut(cyc));
            end
        end
        for (int g = 0; g < 400 && popT < 0; g++) begin
            TxD_data = 8'($urandom);
            advance();
            if (fifo_count !== 3'd4) popT = cyc;
            nCmp++;
            if ({TxD, TxD_busy, TxD_ready, fifo_count} !== modelOut(cyc)) begin
                nFail++;
                $display("FAIL fullpop_line cyc=%0d got=%b exp=%b", cyc,
                         {TxD, TxD_busy, TxD_ready, fifo_count}, modelOut(cyc));
            end
        end
        nCmp++;
        if (popT < 0) begin
            nFail++;
            $display("FAIL fullpop_timeout got=no_pop exp=pop_within_400");
        end else begin
            nCmp++;
            if (popT != n + 1 + FrameClks) begin
                nFail++;
                $display("FAIL fullpop_pop_time got=N+%0d exp=N+%0d", popT - n, 1 + FrameClks);
            end
            nCmp++;
            if (fifo_count !== 3'd3) begin
                nFail++;
                $display("FAIL fullpop_pop_edge_count got=%0d exp=3", fifo_count);
            end
            TxD_data = 8'($urandom);
            advance();
            nCmp++;
            if ({TxD_ready, fifo_count} !== {1'b0, 3'd4}) begin
                nFail++;
                $display("FAIL fullpop_refill got ready=%b count=%0d exp ready=0 count=4",
                         TxD_ready, fifo_count);
            end
        end
        TxD_start = 1'b0;
        for (int g = 0; g < 2000 && cyc < modelEnd() + 2; g++) begin
            advance();
            nCmp++;
            if ({TxD, TxD_busy, TxD_ready, fifo_count} !== modelOut(cyc)) begin
                nFail++;
                $display("FAIL fullpop_drain cyc=%0d got=%b exp=%b", cyc,
                         {TxD, TxD_busy, TxD_ready, fifo_count}, modelOut(cyc));
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        logic active;
        n = 0;
        active = 1'b0;
        TxD_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            TxD_data = (i == 0) ? (8'($urandom) & 8'hF7) : 8'($urandom);
            advance();
            if (i == 0) n = cyc;
        end
        TxD_start = 1'b0;
        while (cyc < n + 1 + 4 * BitClks + 5) begin
            advance();
            nCmp++;
            if ({TxD, TxD_busy, TxD_ready, fifo_count} !== modelOut(cyc)) begin
                nFail++;
                $display("FAIL rstmid_line cyc=%0d got=%b exp=%b", cyc,
                         {TxD, TxD_busy, TxD_ready, fifo_count}, modelOut(cyc));
            end
        end
        #3;
        rst_n = 1'b0;
        resetModel();
        #1;
        nCmp++;
        if ({TxD, TxD_busy, TxD_ready, fifo_count} !== 6'b101000) begin
            nFail++;
            $display("FAIL rstmid_async got=%b exp=%b",
                     {TxD, TxD_busy, TxD_ready, fifo_count}, 6'b101000);
        end
        for (int i = 0; i < 3; i++) advance();
        rst_n = 1'b1;
        for (int i = 0; i < 500; i++) begin
            advance();
            if (!TxD || TxD_busy || fifo_count != 3'd0) active = 1'b1;
            nCmp++;
            if ({TxD, TxD_busy, TxD_ready, fifo_count} !== modelOut(cyc)) begin
                nFail++;
                $display("FAIL rstmid_after cyc=%0d got=%b exp=%b", cyc,
                         {TxD, TxD_busy, TxD_ready, fifo_count}, modelOut(cyc));
            end
        end
        nCmp++;
        if (active !== 1'b0) begin
            nFail++;
            $display("FAIL rstmid_no_resume got=activity exp=idle");
        end
    endtask

    task automatic test_random();
        int density;
        density = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 300 == 0) density = $urandom_range(0, 8);
            TxD_start = (i < 2600) && ($urandom_range(1, 8) <= density);
            TxD_data = 8'($urandom);
            advance();
            nCmp++;
            if ({TxD, TxD_busy, TxD_ready, fifo_count} !== modelOut(cyc)) begin
                nFail++;
                $display("FAIL random_line cyc=%0d got=%b exp=%b", cyc,
                         {TxD, TxD_busy, TxD_ready, fifo_count}, modelOut(cyc));
            end
        end
        TxD_start = 1'b0;
        for (int g = 0; g < 2000 && cyc < modelEnd() + 2; g++) begin
            advance();
            nCmp++;
            if ({TxD, TxD_busy, TxD_ready, fifo_count} !== modelOut(cyc)) begin
                nFail++;
                $display("FAIL random_drain cyc=%0d got=%b exp=%b", cyc,
                         {TxD, TxD_busy, TxD_ready, fifo_count}, modelOut(cyc));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fill();
        test_full_pop_write();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
